// File: rtl/key_event_ahb.sv
// rtl/key_event_ahb.sv - AHB-Lite keypad event FIFO with timestamps and level interrupt
module key_event_ahb #(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_DIV     = 1000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  key_pulse,
  input  logic        HSEL,
  input  logic [11:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        key_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [1:0]    dp_addr;
  logic          dp_write;
  logic          dp_valid;
  logic [PW-1:0] presc;
  logic [11:0]   ts;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [1:0]    ctrl;

  logic        rd_data, wr_data;
  logic        empty, full;
  logic        push_req, flush, ovf_clr;
  logic        do_push, do_pop, ovf_set;
  logic [15:0] head;
  logic        unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = ^{HSIZE, HADDR[11:4], HADDR[1:0], HWDATA[31:2], HTRANS[0]};

  assign rd_data  = dp_valid & ~dp_write;
  assign wr_data  = dp_valid & dp_write;
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign head     = mem[rd_ptr];

  assign push_req = ctrl[0] & (key_pulse != 4'b0);
  assign flush    = wr_data & (dp_addr == 2'd3) & HWDATA[1];
  assign ovf_clr  = wr_data & (dp_addr == 2'd3) & HWDATA[0];
  assign do_pop   = rd_data & (dp_addr == 2'd0) & ~empty;
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_push  = push_req & ~flush & (~full | do_pop);
  assign ovf_set  = push_req & ~flush & full & ~do_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc <= '0;
      ts    <= 12'd0;
    end else if (presc == PW'(TS_DIV - 1)) begin
      presc <= '0;
      ts    <= ts + 12'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= {ts, key_pulse};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf     <= 1'b0;
      ctrl    <= 2'b00;
      key_irq <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (wr_data && dp_addr == 2'd2) ctrl <= HWDATA[1:0];
      key_irq <= ctrl[1] & (~empty | ovf);
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_data) begin
      case (dp_addr)
        2'd0: if (!empty) HRDATA = {1'b1, 3'b000, head[15:4], 12'd0, head[3:0]};
        2'd1: HRDATA = {15'd0, ovf, 6'd0, full, empty, 3'd0, 5'(count)};
        2'd2: HRDATA = {30'd0, ctrl};
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ahb.sv
// tb/tb_key_event_ahb.sv - scoreboard bench for key_event_ahb
module tb_key_event_ahb;

  localparam int TS_DIV = 2;
  localparam int DEPTH  = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [3:0]  key_pulse;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        key_irq;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic rd_seen;
  logic [31:0] exp_q[$];
  string       name_q[$];

  key_event_ahb #(.FIFO_DEPTH(DEPTH), .TS_DIV(TS_DIV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .key_pulse(key_pulse), .HSEL(HSEL),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .key_irq(key_irq)
  );

  always #5 HCLK = ~HCLK;

  // Edge count since reset release mirrors the prescaler/timestamp.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_seen <= 1'b0;
    else          rd_seen <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", HRDATA);
      end else begin
        chk(name_q.pop_front(), HRDATA, exp_q.pop_front());
      end
    end
  end

  function automatic logic [11:0] ts_now();
    return 12'((cyc / TS_DIV) % 4096);
  endfunction

  function automatic logic [31:0] ev(input logic [11:0] t, input logic [3:0] k);
    return {1'b1, 3'b000, t, 12'd0, k};
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {8'h00, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 12'h0; HWDATA = d;
    @(negedge HCLK);
    HWDATA = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm,
                          input logic [3:0] k, output logic [11:0] t);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {8'h00, a};
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 12'h0;
    key_pulse = k;
    t = ts_now();
    @(negedge HCLK);
    key_pulse = 4'd0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    logic [11:0] dummy;
    bus_read(a, exp, nm, 4'd0, dummy);
  endtask

  task automatic pulse(input logic [3:0] k, output logic [11:0] t);
    @(negedge HCLK);
    key_pulse = k;
    t = ts_now();
    @(negedge HCLK);
    key_pulse = 4'd0;
  endtask

  logic [11:0] t0, tn;
  logic [11:0] tq[DEPTH+1];
  int guard;

  initial begin
    HRESETn = 1'b0; key_pulse = 4'd0; HSEL = 1'b0; HADDR = 12'h0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    chk("reset_irq", {31'd0, key_irq}, 32'd0);
    rd(4'h4, 32'h0000_0100, "reset_status");
    rd(4'h0, 32'h0000_0000, "reset_data");
    rd(4'h8, 32'h0000_0000, "reset_ctrl");

    // Single event with interrupt latency
    bus_write(4'h8, 32'h3);
    rd(4'h8, 32'h0000_0003, "ctrl_rb");
    pulse(4'b0010, t0);
    chk("irq_latency0", {31'd0, key_irq}, 32'd0);
    @(negedge HCLK);
    chk("irq_set", {31'd0, key_irq}, 32'd1);
    rd(4'h0, ev(t0, 4'b0010), "single_data");
    chk("irq_hold", {31'd0, key_irq}, 32'd1);
    @(negedge HCLK);
    chk("irq_drop", {31'd0, key_irq}, 32'd0);
    rd(4'h4, 32'h0000_0100, "single_status");

    // Overflow: nine events into an eight-deep FIFO
    bus_write(4'h8, 32'h1);
    for (int i = 0; i < DEPTH + 1; i++) pulse(4'b0001, tq[i]);
    rd(4'h4, 32'h0001_0208, "ovf_status");
    chk("irq_disabled", {31'd0, key_irq}, 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(4'h0, ev(tq[i], 4'b0001), $sformatf("ovf_data%0d", i));
    rd(4'h4, 32'h0001_0100, "ovf_drained");
    bus_write(4'hC, 32'h1);
    rd(4'h4, 32'h0000_0100, "ovf_cleared");

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) pulse(4'b0001, tq[i]);
    rd(4'h4, 32'h0000_0208, "full_status");
    bus_read(4'h0, ev(tq[0], 4'b0001), "full_poppush", 4'b0001, tn);
    rd(4'h4, 32'h0000_0208, "poppush_status");
    for (int i = 1; i < DEPTH; i++) rd(4'h0, ev(tq[i], 4'b0001), $sformatf("pp_data%0d", i));
    rd(4'h0, ev(tn, 4'b0001), "pp_newest");
    rd(4'h4, 32'h0000_0100, "pp_empty");

    // Empty FIFO: DATA read coinciding with a push
    bus_read(4'h0, 32'h0000_0000, "empty_rd_push", 4'b1000, tn);
    rd(4'h4, 32'h0000_0001, "empty_rd_push_cnt");
    rd(4'h0, ev(tn, 4'b1000), "empty_rd_push_data");

    // Multi-key entry and EN=0 gating
    pulse(4'b1011, t0);
    rd(4'h4, 32'h0000_0001, "multi_status");
    bus_write(4'h8, 32'h0);
    pulse(4'b0100, tn);
    rd(4'h4, 32'h0000_0001, "en0_status");
    bus_write(4'h8, 32'h1);
    rd(4'h0, ev(t0, 4'b1011), "multi_data");
    rd(4'h4, 32'h0000_0100, "multi_empty");

    // Timestamp wrap 0xFFF -> 0x000
    bus_write(4'h8, 32'h3);
    guard = 0;
    while ((cyc % 8192) != 8187 && guard < 9000) begin
      @(negedge HCLK);
      guard++;
    end
    chk("wrap_wait_timeout", (guard < 9000) ? 32'd1 : 32'd0, 32'd1);
    pulse(4'b0001, t0);
    pulse(4'b0001, t0);
    pulse(4'b0001, t0);
    rd(4'h0, 32'h8FFE_0001, "ts_ffe");
    rd(4'h0, 32'h8FFF_0001, "ts_fff");
    rd(4'h0, 32'h8000_0001, "ts_000");

    // Flush with three queued entries
    for (int i = 0; i < 3; i++) pulse(4'b0010, t0);
    rd(4'h4, 32'h0000_0003, "preflush_status");
    bus_write(4'hC, 32'h2);
    chk("flush_irq_hold", {31'd0, key_irq}, 32'd1);
    @(negedge HCLK);
    chk("flush_irq_drop", {31'd0, key_irq}, 32'd0);
    rd(4'h4, 32'h0000_0100, "flush_status");
    rd(4'hC, 32'h0000_0000, "clear_reads0");

    repeat (3) @(negedge HCLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_ahb.md
Name: key_event_ahb

Overview:
- AHB-Lite slave that captures the one-cycle per-key pulses produced by the keypad debounce stage.
- Each event is timestamped and queued in a small FIFO; software drains the FIFO via a pop-on-read DATA register.
- Raises a level interrupt to the NVIC while events are pending, so software sees ordered, timestamped key events instead of raw pulses.

Parameters:
- FIFO_DEPTH, 8, number of event entries; must be a power of 2, 2..16.
- TS_DIV, 1000, HCLK cycles per timestamp tick; must be >= 1.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- key_pulse  in  4  one-HCLK pulses from debounce stage, bit n = key n
- HSEL  in  1  slave select
- HADDR  in  12  byte address; only [3:2] decoded
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  tied 1; zero wait states
- HRESP  out  1  tied 0; OKAY
- HRDATA  out  32  read data
- key_irq  out  1  level interrupt

Behaviour:
- Reset: all registers, FIFO pointers, count, OVF, timestamp and prescaler cleared. HRDATA=0, key_irq=0, CTRL=0.
- Bus timing:
  - Address phase is latched when HSEL & HREADY & HTRANS[1]; this captures the address, HWRITE and a valid flag.
  - Writes are applied on the data-phase clock edge.
  - HRDATA is combinational from the latched address and current state; it is 0 when no read is valid.
- Register map (word offset):
  - 0x0 DATA (RO): {valid[31], 0[30:28], ts[27:16], 0[15:4], keys[3:0]} of the FIFO head. valid=0 and all other bits 0 when empty. A valid read pops the FIFO at the end of the data phase.
  - 0x4 STATUS (RO): count[4:0], empty[8], full[9], ovf[16].
  - 0x8 CTRL (RW): EN[0], IRQ_EN[1]; other bits read 0.
  - 0xC CLEAR (WO, reads 0): bit0=1 clears OVF; bit1=1 flushes the FIFO (count=0, pointers reset). Both bits may be set in one write.
- Timestamp:
  - Prescaler counts 0..TS_DIV-1; ts (12-bit) increments when the prescaler wraps.
  - ts wraps 0xFFF->0x000. It runs regardless of EN.
- Capture:
  - When EN=1 and key_pulse!=0, push one entry {ts, key_pulse} in the same cycle. Simultaneous keys share one entry with multiple mask bits.
  - When EN=0, pulses are ignored.
- Push/pop interactions:
  - Full, push and no pop: the new event is dropped, OVF is set (sticky), and FIFO contents are unchanged.
  - Full, push and pop in the same cycle: pop then push; count unchanged; OVF not set.
  - Empty and a DATA read in the same cycle as a push: the read returns valid=0, the push is stored, count becomes 1.
  - Flush coinciding with a push: flush wins; the event is lost and OVF is not set.
  - OVF clear coinciding with a new overflow: OVF stays 1 (set wins).
- Interrupt:
  - key_irq is registered: key_irq <= IRQ_EN & ((count!=0) | OVF). One cycle latency after the condition changes.
  - Deasserts the cycle after the FIFO empties and OVF clears, or after IRQ_EN is written 0.
- Width rules: count ranges 0..FIFO_DEPTH; pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-operation: asynchronous; all state is cleared immediately and no partial bus transfer completes.

Test Plan:
- Reset, then read STATUS -> 0x0000_0100 (empty=1); read DATA -> 0; key_irq=0.
- CTRL=0x3, pulse key_pulse=4'b0010 at ts=5 -> key_irq=1 one cycle later. DATA read -> 0x8005_0002. Next STATUS -> empty; key_irq drops the cycle after.
- CTRL=0x1, 9 separate pulses of 4'b0001 with FIFO_DEPTH=8 -> STATUS count=8, full=1, ovf=1. Eight DATA reads return the first 8 events in order. CLEAR=0x1 -> ovf=0.
- With FIFO full, a DATA read in the same cycle as a new pulse -> count stays 8, ovf=0, and the last entry is the new event.
- key_pulse=4'b1011 in one cycle -> single entry with keys=0xB. CTRL.EN=0 plus a pulse -> count unchanged.
- TS_DIV=2, ts preloaded near wrap: observe ts go 0xFFF->0x000 in captured entries. CLEAR=0x2 with 3 queued entries -> count=0; key_irq=0 one cycle later.
